fwd_ctrl: RTL and testbench

- Hazard and forwarding control unit that drives the operand-selection controls of the EX-stage operand/forwarding datapath: A1/B1 4-way forward select, A2/B2 PC/immediate select, BrUn.
- Tracks destination-register metadata for the EX, MEM and WB pipeline slots.
- Computes forward selects for the instruction in EX and generates load-use stalls.
- Sits beside the decode stage and consumes decoded register fields.

---
 rtl/fwd_ctrl_if.sv | 40 ++++
 rtl/fwd_ctrl.sv | 116 +++++++++++
 tb/tb_fwd_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_ctrl_if.sv
// Decode-side request and EX operand-control bundle for fwd_ctrl.
interface fwd_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_we_i;
  logic              id_load_i;
  logic              id_pc_sel_i;
  logic              id_imm_sel_i;
  logic              id_brun_i;
  logic              flush_i;
  logic              hold_i;

  logic [1:0]        A1_sel_o;
  logic [1:0]        B1_sel_o;
  logic              A2_sel_o;
  logic              B2_sel_o;
  logic              BrUn_o;
  logic              stall_o;
  logic              ex_valid_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_we_i, id_load_i, id_pc_sel_i, id_imm_sel_i, id_brun_i,
           flush_i, hold_i,
    input  A1_sel_o, B1_sel_o, A2_sel_o, B2_sel_o, BrUn_o, stall_o, ex_valid_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_we_i, id_load_i, id_pc_sel_i, id_imm_sel_i, id_brun_i,
           flush_i, hold_i,
    output A1_sel_o, B1_sel_o, A2_sel_o, B2_sel_o, BrUn_o, stall_o, ex_valid_o
  );
endinterface

// File: rtl/fwd_ctrl.sv
// Hazard/forwarding control for the EX operand muxes: tracks EX/MEM/WB destinations.
// Optional FWD_CTRL_MEM_FWD_EN: forward load data from MEM instead of stalling.
module fwd_ctrl #(
  parameter int unsigned REG_AW = 5
) (
  input  logic       clk,
  input  logic       rst,
  fwd_ctrl_if.slave  bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
`ifdef FWD_CTRL_MEM_FWD_EN
  localparam logic [1:0] SEL_MEM_LOAD = 2'b11;
  localparam logic       LOAD_USE_EN  = 1'b0;
`else
  // Without a memory-data path the consumer waits a cycle and takes WB instead.
  localparam logic [1:0] SEL_MEM_LOAD = 2'b00;
  localparam logic       LOAD_USE_EN  = 1'b1;
`endif

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

  typedef struct packed {
    slot_t             dst;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic              pc_sel;
    logic              imm_sel;
    logic              brun;
  } ex_slot_t;

  ex_slot_t ex_q, ex_d;
  slot_t    mem_q, mem_d, wb_q, wb_d;

  logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic load_use;

  function automatic logic slot_match(slot_t s, logic [REG_AW-1:0] r, logic use_r);
    return s.valid & s.we & use_r & (r != '0) & (s.rd == r);
  endfunction

  function automatic logic [1:0] pick_sel(logic mem_hit, logic mem_load, logic wb_hit);
    if (mem_hit)     return mem_load ? SEL_MEM_LOAD : SEL_ALU;
    else if (wb_hit) return SEL_WB;
    else             return SEL_RF;
  endfunction

  // Slot registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Hazard detection and slot advance
  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    mem_hit1 = ex_q.dst.valid & slot_match(mem_q, ex_q.rs1, ex_q.use_rs1);
    mem_hit2 = ex_q.dst.valid & slot_match(mem_q, ex_q.rs2, ex_q.use_rs2);
    wb_hit1  = ex_q.dst.valid & slot_match(wb_q,  ex_q.rs1, ex_q.use_rs1);
    wb_hit2  = ex_q.dst.valid & slot_match(wb_q,  ex_q.rs2, ex_q.use_rs2);
    load_use = LOAD_USE_EN & mem_q.load & (mem_hit1 | mem_hit2);

    if (bus.hold_i) begin
      ex_d  = ex_q;
    end else if (bus.flush_i) begin
      // The redirecting EX instruction retires; only the ID entry is dropped.
      wb_d  = mem_q;
      mem_d = ex_q.dst;
      ex_d  = '0;
    end else if (load_use) begin
      wb_d  = mem_q;
      mem_d = '0;
    end else begin
      wb_d              = mem_q;
      mem_d             = ex_q.dst;
      ex_d.dst.valid    = bus.id_valid_i;
      ex_d.dst.rd       = bus.id_rd_i;
      ex_d.dst.we       = bus.id_we_i;
      ex_d.dst.load     = bus.id_load_i;
      ex_d.rs1          = bus.id_rs1_i;
      ex_d.rs2          = bus.id_rs2_i;
      ex_d.use_rs1      = bus.id_use_rs1_i;
      ex_d.use_rs2      = bus.id_use_rs2_i;
      ex_d.pc_sel       = bus.id_pc_sel_i;
      ex_d.imm_sel      = bus.id_imm_sel_i;
      ex_d.brun         = bus.id_brun_i;
    end
  end

  assign bus.A1_sel_o   = pick_sel(mem_hit1, mem_q.load, wb_hit1);
  assign bus.B1_sel_o   = pick_sel(mem_hit2, mem_q.load, wb_hit2);
  assign bus.A2_sel_o   = ex_q.dst.valid & ex_q.pc_sel;
  assign bus.B2_sel_o   = ex_q.dst.valid & ex_q.imm_sel;
  assign bus.BrUn_o     = ex_q.dst.valid & ex_q.brun;
  assign bus.ex_valid_o = ex_q.dst.valid;
  assign bus.stall_o    = rst & ~bus.hold_i & ~bus.flush_i & load_use;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed hazard scenarios plus random traffic vs a pipeline model.
module tb_fwd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fwd_ctrl_if #(.REG_AW(5)) bus ();
  fwd_ctrl #(.REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit valid;
    int rd, rs1, rs2;
    bit u1, u2, we, load, pc, imm, brun;
  } ins_t;

  ins_t m_ex, m_mem, m_wb, cur, bubble;
  bit   cur_flush, cur_hold;

`ifdef FWD_CTRL_MEM_FWD_EN
  localparam bit MEM_FWD = 1'b1;
`else
  localparam bit MEM_FWD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit we, bit ld);
    ins_t i;
    i = '{valid: v, rd: rd, rs1: rs1, rs2: rs2, u1: u1, u2: u2, we: we, load: ld,
          pc: 1'b0, imm: 1'b0, brun: 1'b0};
    return i;
  endfunction

  // Distance (1 = MEM, 2 = WB) of the youngest older instruction writing r, 0 if none.
  function automatic int producer(int r, bit used);
    ins_t older [2];
    older[0] = m_mem;
    older[1] = m_wb;
    if (!m_ex.valid || !used || r == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (older[k].valid && older[k].we && older[k].rd == r) return k + 1;
    return 0;
  endfunction

  function automatic int exp_sel(int r, bit used);
    case (producer(r, used))
      1:       return m_mem.load ? (MEM_FWD ? 3 : 0) : 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit load_use();
    if (MEM_FWD) return 1'b0;
    return m_mem.load && (producer(m_ex.rs1, m_ex.u1) == 1 || producer(m_ex.rs2, m_ex.u2) == 1);
  endfunction

  task automatic drive(input ins_t i, input bit fl, input bit hd);
    cur = i; cur_flush = fl; cur_hold = hd;
    bus.id_valid_i   = i.valid;
    bus.id_rd_i      = 5'(i.rd);
    bus.id_rs1_i     = 5'(i.rs1);
    bus.id_rs2_i     = 5'(i.rs2);
    bus.id_use_rs1_i = i.u1;
    bus.id_use_rs2_i = i.u2;
    bus.id_we_i      = i.we;
    bus.id_load_i    = i.load;
    bus.id_pc_sel_i  = i.pc;
    bus.id_imm_sel_i = i.imm;
    bus.id_brun_i    = i.brun;
    bus.flush_i      = fl;
    bus.hold_i       = hd;
    #1;
  endtask

  // Compare every output against the model, then clock once and advance the model.
  task automatic step();
    check("A1_sel",   32'(bus.A1_sel_o),   32'(exp_sel(m_ex.rs1, m_ex.u1)));
    check("B1_sel",   32'(bus.B1_sel_o),   32'(exp_sel(m_ex.rs2, m_ex.u2)));
    check("A2_sel",   32'(bus.A2_sel_o),   32'(m_ex.valid && m_ex.pc));
    check("B2_sel",   32'(bus.B2_sel_o),   32'(m_ex.valid && m_ex.imm));
    check("BrUn",     32'(bus.BrUn_o),     32'(m_ex.valid && m_ex.brun));
    check("ex_valid", 32'(bus.ex_valid_o), 32'(m_ex.valid));
    check("stall",    32'(bus.stall_o),    32'(rst && !cur_hold && !cur_flush && load_use()));
    @(posedge clk);
    if (!rst) begin
      m_ex = bubble; m_mem = bubble; m_wb = bubble;
    end else if (cur_hold) begin
      m_ex = m_ex;
    end else if (cur_flush) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = bubble;
    end else if (load_use()) begin
      m_wb = m_mem; m_mem = bubble;
    end else begin
      m_wb = m_mem; m_mem = m_ex; m_ex = cur;
    end
    @(negedge clk);
  endtask

  task automatic issue(input ins_t i);
    drive(i, 1'b0, 1'b0);
    step();
  endtask

  ins_t nop, add5, sub_a, sub_b, add0, use0, lw3, add4, r;

  initial begin
    bubble = mk(0, 0, 0, 0, 0, 0, 0, 0);
    nop    = bubble;
    add5   = mk(1, 5, 1, 2, 1, 1, 1, 0);
    sub_a  = mk(1, 6, 5, 7, 1, 1, 1, 0);
    sub_b  = mk(1, 6, 7, 5, 1, 1, 1, 0);
    add0   = mk(1, 0, 1, 2, 1, 1, 1, 0);
    use0   = mk(1, 8, 0, 0, 1, 1, 1, 0);
    lw3    = mk(1, 3, 1, 0, 1, 0, 1, 1);
    add4   = mk(1, 4, 3, 3, 1, 1, 1, 0);
    m_ex = bubble; m_mem = bubble; m_wb = bubble;

    // Reset held with a valid instruction presented
    rst = 1'b0;
    drive(add5, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(add5, 1'b0, 1'b0);
    check("rst_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    check("rst_a1", 32'(bus.A1_sel_o), 32'd0);
    step();
    rst = 1'b1;
    drive(add5, 1'b0, 1'b0);
    check("first_cycle_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    step();
    drive(nop, 1'b0, 1'b0);
    check("accepted_ex_valid", 32'(bus.ex_valid_o), 32'd1);
    step();
    repeat (3) issue(nop);

    // Back-to-back ALU dependency
    issue(add5); issue(sub_a);
    drive(nop, 1'b0, 1'b0);
    check("alu_fwd_a1", 32'(bus.A1_sel_o), 32'd1);
    check("alu_fwd_b1", 32'(bus.B1_sel_o), 32'd0);
    step();
    repeat (3) issue(nop);

    // Distance-2 dependency via write-back
    issue(add5); issue(nop); issue(sub_b);
    drive(nop, 1'b0, 1'b0);
    check("wb_fwd_b1", 32'(bus.B1_sel_o), 32'd2);
    step();
    repeat (3) issue(nop);

    // x0 never forwards
    issue(add0); issue(use0);
    drive(nop, 1'b0, 1'b0);
    check("x0_a1", 32'(bus.A1_sel_o), 32'd0);
    check("x0_b1", 32'(bus.B1_sel_o), 32'd0);
    step();
    repeat (3) issue(nop);

    // Load-use
    issue(lw3); issue(add4);
    drive(nop, 1'b0, 1'b0);
`ifdef FWD_CTRL_MEM_FWD_EN
    check("ldfwd_a1", 32'(bus.A1_sel_o), 32'd3);
    check("ldfwd_b1", 32'(bus.B1_sel_o), 32'd3);
    check("ldfwd_stall", 32'(bus.stall_o), 32'd0);
    step();
`else
    check("lduse_stall", 32'(bus.stall_o), 32'd1);
    step();
    drive(nop, 1'b0, 1'b0);
    check("lduse_stall_end", 32'(bus.stall_o), 32'd0);
    check("lduse_a1", 32'(bus.A1_sel_o), 32'd2);
    check("lduse_b1", 32'(bus.B1_sel_o), 32'd2);
    step();
`endif
    repeat (3) issue(nop);

    // MEM has priority over WB for the same register
    issue(add5); issue(add5); issue(sub_a);
    drive(nop, 1'b0, 1'b0);
    check("mem_over_wb", 32'(bus.A1_sel_o), 32'd1);
    step();
    repeat (3) issue(nop);

    // Flush beats a pending load-use
    issue(lw3); issue(add4);
    drive(add5, 1'b1, 1'b0);
    check("flush_stall", 32'(bus.stall_o), 32'd0);
    step();
    drive(nop, 1'b0, 1'b0);
    check("flush_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    check("flush_stall_next", 32'(bus.stall_o), 32'd0);
    step();
    repeat (3) issue(nop);

    // Hold freezes slots for three cycles
    issue(add5); issue(sub_a);
    for (int k = 0; k < 3; k++) begin
      drive(add4, 1'b0, 1'b1);
      check("hold_a1", 32'(bus.A1_sel_o), 32'd1);
      check("hold_ex_valid", 32'(bus.ex_valid_o), 32'd1);
      step();
    end
    drive(nop, 1'b0, 1'b0);
    check("hold_release_a1", 32'(bus.A1_sel_o), 32'd1);
    step();
    repeat (3) issue(nop);

    // Random traffic with a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      r = mk($urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      r.pc   = $urandom_range(0, 1) != 0;
      r.imm  = $urandom_range(0, 1) != 0;
      r.brun = $urandom_range(0, 1) != 0;
      rst = ($urandom_range(0, 49) != 0);
      drive(r, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
